// File: rtl/path_issue_ctrl.sv
// path_issue_ctrl: shares one combinational smallPath generator among NREQ
// requesters. A round-robin arbiter grants one request, its fields drive
// smallPath for one LOAD cycle, the returned path is captured, and its hops
// are streamed one per handshake to the router injection port.
module path_issue_ctrl #(
  parameter int NREQ = 4,
  parameter int HOPS = 16,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int IXW = $clog2(HOPS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_group,
  input  logic [3*NREQ-1:0]    req_len0,
  input  logic [2*NREQ-1:0]    req_len1,
  input  logic [2*NREQ-1:0]    req_len2,
  input  logic [8*NREQ-1:0]    req_data0,
  input  logic [6*NREQ-1:0]    req_data1,
  input  logic [4*NREQ-1:0]    req_data2,
  input  logic [5*NREQ-1:0]    req_nhops,
  output logic [1:0]           sp_group,
  output logic [2:0]           sp_len_0,
  output logic [1:0]           sp_len_1,
  output logic [1:0]           sp_len_2,
  output logic [7:0]           sp_data_0,
  output logic [5:0]           sp_data_1,
  output logic [3:0]           sp_data_2,
  input  logic [2*HOPS-1:0]    sp_path,
  output logic                 hop_valid,
  input  logic                 hop_ready,
  output logic [1:0]           hop_dim,
  output logic                 hop_last,
  output logic [IDW-1:0]       hop_src,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [IXW-1:0]      idx_q, idx_d;
  logic [2*HOPS-1:0]   path_q, path_d;
  logic [4:0]          nhops_q, nhops_d;
  logic [IDW-1:0]      src_q, src_d;
  logic [1:0]          group_q, group_d;
  logic [2:0]          len0_q, len0_d;
  logic [1:0]          len1_q, len1_d;
  logic [1:0]          len2_q, len2_d;
  logic [7:0]          data0_q, data0_d;
  logic [5:0]          data1_q, data1_d;
  logic [3:0]          data2_q, data2_d;
  logic                hop_valid_q, hop_valid_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  logic                grant_found_s;
  logic [IDW-1:0]      grant_idx_s;
  logic [IDW:0]        cand_s;
  logic                hit_s;
  logic [1:0]          sel_group_s;
  logic [4:0]          sel_nhops_s;
  logic                sel_legal_s;
  logic                hop_last_s;

  // Round-robin search: first valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    hit_s         = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s = {1'b0, rr_q} + (IDW+1)'(i);
      if (cand_s >= (IDW+1)'(NREQ)) begin
        cand_s = cand_s - (IDW+1)'(NREQ);
      end else begin
        cand_s = cand_s;
      end
      hit_s         = !grant_found_s && req_valid[cand_s[IDW-1:0]];
      grant_idx_s   = hit_s ? cand_s[IDW-1:0] : grant_idx_s;
      grant_found_s = grant_found_s | hit_s;
    end
  end

  // Field extraction and legality check for the granted requester.
  always_comb begin
    sel_group_s = req_group[int'(grant_idx_s)*2 +: 2];
    sel_nhops_s = req_nhops[int'(grant_idx_s)*5 +: 5];
    sel_legal_s = (sel_group_s != 2'd0) && (sel_nhops_s != 5'd0) &&
                  (sel_nhops_s <= 5'(HOPS));
  end

  // Grant is combinational so a requester sees ready in the same IDLE cycle.
  always_comb begin
    if ((state_q == ST_IDLE) && grant_found_s) begin
      req_ready = NREQ'(1) << grant_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Final-hop detect against the latched hop count.
  always_comb begin
    hop_last_s = ({1'b0, idx_q} == (nhops_q - 5'd1));
  end

  // Next-state logic for the issue FSM and all datapath registers.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    idx_d     = idx_q;
    path_d    = path_q;
    nhops_d   = nhops_q;
    src_d     = src_q;
    group_d   = group_q;
    len0_d    = len0_q;
    len1_d    = len1_q;
    len2_d    = len2_q;
    data0_d   = data0_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          rr_d = (grant_idx_s == IDW'(NREQ-1)) ? '0 : grant_idx_s + IDW'(1);
          if (sel_legal_s) begin
            state_d = ST_LOAD;
            src_d   = grant_idx_s;
            nhops_d = sel_nhops_s;
            group_d = sel_group_s;
            len0_d  = req_len0[int'(grant_idx_s)*3 +: 3];
            len1_d  = req_len1[int'(grant_idx_s)*2 +: 2];
            len2_d  = req_len2[int'(grant_idx_s)*2 +: 2];
            data0_d = req_data0[int'(grant_idx_s)*8 +: 8];
            data1_d = req_data1[int'(grant_idx_s)*6 +: 6];
            data2_d = req_data2[int'(grant_idx_s)*4 +: 4];
          end else begin
            // Illegal requests are consumed but only flagged; no path is issued.
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        path_d  = sp_path;
        idx_d   = '0;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (hop_ready) begin
          if (hop_last_s) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IXW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
    hop_valid_d = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and datapath registers; async reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      idx_q       <= '0;
      path_q      <= '0;
      nhops_q     <= 5'd0;
      src_q       <= '0;
      group_q     <= 2'd0;
      len0_q      <= 3'd0;
      len1_q      <= 2'd0;
      len2_q      <= 2'd0;
      data0_q     <= 8'd0;
      data1_q     <= 6'd0;
      data2_q     <= 4'd0;
      hop_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      path_q      <= path_d;
      nhops_q     <= nhops_d;
      src_q       <= src_d;
      group_q     <= group_d;
      len0_q      <= len0_d;
      len1_q      <= len1_d;
      len2_q      <= len2_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      hop_valid_q <= hop_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign sp_group  = group_q;
  assign sp_len_0  = len0_q;
  assign sp_len_1  = len1_q;
  assign sp_len_2  = len2_q;
  assign sp_data_0 = data0_q;
  assign sp_data_1 = data1_q;
  assign sp_data_2 = data2_q;
  assign hop_valid = hop_valid_q;
  assign hop_dim   = hop_valid_q ? path_q[{idx_q, 1'b0} +: 2] : 2'd0;
  assign hop_last  = hop_valid_q & hop_last_s;
  assign hop_src   = src_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
